// File: rtl/note_rom_arbiter_if.sv
// Bus bundle between the channel sequencers, the shared song ROM and note_rom_arbiter.
// ROM protocol: o_rom_en is a one-cycle read strobe. The ROM samples o_rom_en/o_rom_addr on
// the next clock edge and drives i_rom_data for the whole following cycle. It has no ready signal.
interface note_rom_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic [4*ADDR_WIDTH-1:0] i_ch_addr;
  logic                    i_invalidate;
  logic [4*DATA_WIDTH-1:0] o_ch_data;
  logic [3:0]              o_ch_valid;
  logic                    o_rom_en;
  logic [ADDR_WIDTH+1:0]   o_rom_addr;
  logic [DATA_WIDTH-1:0]   i_rom_data;

  modport slave (
    input  i_ch_addr,
    input  i_invalidate,
    input  i_rom_data,
    output o_ch_data,
    output o_ch_valid,
    output o_rom_en,
    output o_rom_addr
  );

  modport master (
    output i_ch_addr,
    output i_invalidate,
    output i_rom_data,
    input  o_ch_data,
    input  o_ch_valid,
    input  o_rom_en,
    input  o_rom_addr
  );
endinterface

// File: rtl/note_rom_arbiter.sv
// Round-robin arbiter that lets four note sequencers share one synchronous song ROM.
// Each channel caches one note word, tagged with the index it was fetched for.
module note_rom_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  note_rom_arbiter_if.slave      bus,
  output logic [1:0]             o_dbg_state
);

  localparam int NUM_CH    = 4;
  localparam int ROM_AW    = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    rom_en_q, rom_en_d;
  logic [ROM_AW-1:0]       rom_addr_q, rom_addr_d;
  logic [1:0]              rr_q, rr_d;
  logic [1:0]              gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    capture;

  logic [DATA_WIDTH-1:0]   data_q   [NUM_CH];
  logic [ADDR_WIDTH-1:0]   tag_q    [NUM_CH];
  logic [NUM_CH-1:0]       loaded_q;

  logic [ADDR_WIDTH-1:0]   ch_addr  [NUM_CH];
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH-1:0]       pending;
  logic                    any_pending;
  logic [1:0]              gnt_sel;
  logic [1:0]              cand;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_addr[c] = bus.i_ch_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Valid compares against the live index, so a changed index drops valid immediately
  // and a fetch issued for an older index can never be reported as valid.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_valid[c] = loaded_q[c] && (tag_q[c] == ch_addr[c]);
    end
  end

  assign pending = ~ch_valid;

  // Walk from the highest rotation distance down so the nearest pending channel wins.
  always_comb begin
    any_pending = 1'b0;
    gnt_sel     = rr_q;
    cand        = rr_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (pending[cand]) begin
        any_pending = 1'b1;
        gnt_sel     = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rr_q       <= 2'd0;
      gnt_q      <= 2'd0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_pending) begin
          state_d    = S_ISSUE;
          rom_en_d   = 1'b1;
          rom_addr_d = {gnt_sel, ch_addr[gnt_sel]};
          gnt_d      = gnt_sel;
          idx_d      = ch_addr[gnt_sel];
          rr_d       = gnt_sel + 2'd1;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Invalidate overrides a coincident capture: the word is stored but left unloaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loaded_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c] <= '0;
        tag_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (capture && (gnt_q == 2'(c))) begin
          data_q[c]   <= bus.i_rom_data;
          tag_q[c]    <= idx_q;
          loaded_q[c] <= !bus.i_invalidate;
        end else if (bus.i_invalidate) begin
          loaded_q[c] <= 1'b0;
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign bus.o_ch_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q[c];
  end

  assign bus.o_ch_valid = ch_valid;
  assign bus.o_rom_en   = rom_en_q;
  assign bus.o_rom_addr = rom_addr_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_note_rom_arbiter.sv
// Directed bench for note_rom_arbiter with a word-equals-address ROM model.
// Expected addresses, valid masks and data words are hand-computed per step.
module tb_note_rom_arbiter;

  localparam int AW = 5;
  localparam int DW = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  logic [DW-1:0] rom_mem [128];

  note_rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  note_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle synchronous read
  always @(posedge clk) begin
    if (bus.o_rom_en) bus.i_rom_data <= rom_mem[bus.o_rom_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] v);
    bus.i_ch_addr[ch*AW +: AW] = v;
  endtask

  function automatic logic [DW-1:0] ch_data(input int ch);
    return bus.o_ch_data[ch*DW +: DW];
  endfunction

  // One full fetch: issue, ROM cycle, capture.
  task automatic fetch_check(input int ch, input logic [6:0] a, input logic [3:0] vmask);
    tick();
    check_eq($sformatf("issue_en_ch%0d", ch), 32'(bus.o_rom_en), 32'd1);
    check_eq($sformatf("issue_addr_ch%0d", ch), 32'(bus.o_rom_addr), 32'(a));
    check_eq($sformatf("issue_state_ch%0d", ch), 32'(dbg_state), 32'd1);
    tick();
    check_eq($sformatf("en_drop_ch%0d", ch), 32'(bus.o_rom_en), 32'd0);
    tick();
    check_eq($sformatf("valid_after_ch%0d", ch), 32'(bus.o_ch_valid), 32'(vmask));
    check_eq($sformatf("data_ch%0d", ch), 32'(ch_data(ch)), 32'(a));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int a = 0; a < 128; a++) rom_mem[a] = 16'(a);
    rst_n            = 1'b0;
    bus.i_ch_addr    = '0;
    bus.i_invalidate = 1'b0;
    bus.i_rom_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rom_en", 32'(bus.o_rom_en), 32'd0);
    check_eq("rst_rom_addr", 32'(bus.o_rom_addr), 32'd0);
    check_eq("rst_valid", 32'(bus.o_ch_valid), 32'd0);
    check_eq("rst_data", 32'(bus.o_ch_data == '0), 32'd1);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // startup fill: channels 0..3 valid at edges 3/6/9/12
    fetch_check(0, 7'h00, 4'b0001);
    fetch_check(1, 7'h20, 4'b0011);
    fetch_check(2, 7'h40, 4'b0111);
    fetch_check(3, 7'h60, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_en", 32'(bus.o_rom_en), 32'd0);
    end

    // single channel index change
    set_addr(2, 5'd7);
    #1;
    check_eq("ch2_drop", 32'(bus.o_ch_valid), 32'b1011);
    fetch_check(2, 7'h47, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("single_fetch_idle", 32'(bus.o_rom_en), 32'd0);
    end

    // park rr at 2 via a channel 1 fetch, then change all four together
    set_addr(1, 5'd5);
    fetch_check(1, 7'h25, 4'b1111);
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    set_addr(2, 5'd3);
    set_addr(3, 5'd4);
    #1;
    check_eq("all_drop", 32'(bus.o_ch_valid), 32'd0);
    fetch_check(2, 7'h43, 4'b0100);
    fetch_check(3, 7'h64, 4'b1100);
    fetch_check(0, 7'h01, 4'b1101);
    fetch_check(1, 7'h22, 4'b1111);

    // index change while channel 1 is in CAPTURE
    set_addr(1, 5'd3);
    tick();
    check_eq("race_issue_addr", 32'(bus.o_rom_addr), 32'h23);
    tick();
    set_addr(1, 5'd4);
    tick();
    check_eq("race_valid", 32'(bus.o_ch_valid), 32'b1101);
    check_eq("race_stale_data", 32'(ch_data(1)), 32'h23);
    fetch_check(1, 7'h24, 4'b1111);

    // invalidate on the capture edge of a channel 0 fetch
    set_addr(0, 5'd9);
    tick();
    check_eq("inv_issue_addr", 32'(bus.o_rom_addr), 32'h09);
    tick();
    bus.i_invalidate = 1'b1;
    tick();
    bus.i_invalidate = 1'b0;
    check_eq("inv_valid", 32'(bus.o_ch_valid), 32'd0);
    check_eq("inv_data0", 32'(ch_data(0)), 32'h09);
    fetch_check(1, 7'h24, 4'b0010);
    fetch_check(2, 7'h43, 4'b0110);
    fetch_check(3, 7'h64, 4'b1110);
    fetch_check(0, 7'h09, 4'b1111);

    // asynchronous reset while a read is issued
    set_addr(3, 5'h1f);
    tick();
    check_eq("pre_rst_en", 32'(bus.o_rom_en), 32'd1);
    check_eq("pre_rst_addr", 32'(bus.o_rom_addr), 32'h7f);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_en", 32'(bus.o_rom_en), 32'd0);
    check_eq("async_rst_valid", 32'(bus.o_ch_valid), 32'd0);
    check_eq("async_rst_addr", 32'(bus.o_rom_addr), 32'd0);
    check_eq("async_rst_data", 32'(bus.o_ch_data == '0), 32'd1);
    check_eq("async_rst_state", 32'(dbg_state), 32'd0);
    #2;
    rst_n = 1'b1;
    fetch_check(0, 7'h09, 4'b0001);
    fetch_check(1, 7'h24, 4'b0011);
    fetch_check(2, 7'h43, 4'b0111);
    fetch_check(3, 7'h7f, 4'b1111);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/note_rom_arbiter.md
# note_rom_arbiter

Shares one synchronous song ROM between four channel note sequencers. Each sequencer presents a 5-bit note index. The arbiter fetches the matching 16-bit note word from that channel's 32-entry ROM region and holds it in a per-channel register with a valid flag. It sits between the channel sequencers (their address/data pins) and the single block-RAM ROM instance.

## Interface
- `ADDR_WIDTH`, 5, per-channel note index width
- `DATA_WIDTH`, 16, note word width
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_ch_addr`  in  4*ADDR_WIDTH  packed channel note indexes; channel c at bits [c*ADDR_WIDTH +: ADDR_WIDTH]
- `i_invalidate`  in  1  single-cycle strobe; forces all channels to refetch (ROM reloaded)
- `o_ch_data`  out  4*DATA_WIDTH  packed held note words, same packing as `i_ch_addr`
- `o_ch_valid`  out  4  bit c = `o_ch_data` for channel c matches its current `i_ch_addr`
- `o_rom_en`  out  1  ROM read enable (registered)
- `o_rom_addr`  out  ADDR_WIDTH+2  ROM address = {channel[1:0], index} (registered)
- `i_rom_data`  in  DATA_WIDTH  ROM read data, valid the cycle after the ROM samples `o_rom_en`

## Operation
- Per channel c, the block holds:
  - `data[c]`: note word
  - `tag[c]`: the index it was fetched for
  - `loaded[c]`: flag
- `o_ch_valid[c] = loaded[c] && tag[c] == i_ch_addr[c]`. This is combinational from the registers and the current input.
- `pending[c] = !o_ch_valid[c]`.
- Round-robin pointer `rr` (2 bits), reset 0:
  - The grant goes to the first pending channel searching rr, rr+1, ... with mod-4 wrap-around.
  - After a grant, `rr` is set to granted+1 (mod 4).
- FSM states IDLE, ISSUE, CAPTURE:
  - IDLE: if any pending, register `o_rom_en`=1, `o_rom_addr`={g, i_ch_addr[g]}, latch granted channel g and issued index, go ISSUE. Otherwise stay, `o_rom_en`=0.
  - ISSUE: `o_rom_en` deasserts at the next edge; go CAPTURE. The ROM samples the address on this edge.
  - CAPTURE: at the next edge, write `data[g]`=i_rom_data, `tag[g]`=issued index, `loaded[g]`=1; go IDLE.
- Address change during a fetch: `tag` records the issued index, not the current one, so `o_ch_valid` stays 0 and the channel refetches on a later round. Stale data is never flagged valid.
- `i_invalidate`: all `loaded` clear at the next edge.
  - If it coincides with the CAPTURE edge, the data is written but `loaded[g]` ends 0 (invalidate wins).
  - An in-flight FSM sequence is not aborted.
- Reset (async assert, any state):
  - All `loaded`, `tag`, `data` = 0; `o_ch_valid` = 0; `o_ch_data` = 0.
  - `o_rom_en` = 0; `o_rom_addr` = 0; `rr` = 0; state IDLE.
  - Reset mid-fetch discards the fetch.

## Timing
- Arbitration decision at edge E0 (state IDLE → ISSUE).
- `o_rom_en` high for exactly one cycle (E0 to E1).
- ROM data present after E1.
- Channel register and `o_ch_valid` update at E2.
- Earliest next grant is at E3, so sustained throughput is one fetch per 3 cycles.
- Latency:
  - Best case from `i_ch_addr` change to `o_ch_valid`=1: 3 edges (change visible before E0).
  - Worst case with all four pending: 12 edges.
- After reset release with nothing else changing: channels 0, 1, 2, 3 become valid at edges 3, 6, 9, 12.
- `o_rom_en`, `o_rom_addr`, `o_ch_data` are registered outputs. `o_ch_valid` is combinational from registers plus `i_ch_addr`.

## Test plan
- Reset then idle, all `i_ch_addr`=0, ROM preloaded with word = address:
  - `o_rom_addr` sequence 0x00, 0x20, 0x40, 0x60, one issue per 3 cycles.
  - `o_ch_valid` goes 0001, 0011, 0111, 1111 at edges 3/6/9/12.
  - `o_rom_en` stays 0 thereafter.
- Change channel 2 index to 7 only: exactly one fetch at `o_rom_addr`=0x47, `o_ch_valid[2]` drops to 0 immediately, returns to 1 three edges later, `o_ch_data[2]`=0x0047.
- Change all four indexes in the same cycle with `rr`=2: grant order 2, 3, 0, 1, all valid within 12 edges.
- Change channel 1 index from 3 to 4 during its CAPTURE: data for 3 written, `o_ch_valid[1]` stays 0, refetch at 0x24, then valid with data 0x0024.
- `i_invalidate` coinciding with a CAPTURE edge: all `o_ch_valid`=0 the next cycle, four refetches follow, all valid again 12 edges later.
- Assert `i_rst_n`=0 while `o_rom_en`=1: `o_rom_en` and all `o_ch_valid` drop without waiting for a clock edge; after release, fetch order restarts at channel 0.
